sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter_pkg.sv | 34 +++
 rtl/sqrt_arbiter_sqrtarruns.sv | 41 ++++
 rtl/sqrt_arbiter.sv | 95 +++++++++
 tb/tb_sqrt_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arbiter_pkg.sv
// Shared widths, helper functions and pipeline stage records for sqrt_arbiter.
package sqrt_arbiter_pkg;

   // Largest configuration the stage records can carry.
   localparam int MaxWidthX  = 32;
   localparam int MaxWidthQ  = (MaxWidthX + 1) / 2;
   localparam int MaxWidthId = 4;

   // Root width for an operand of wx bits.
   function automatic int width_q(input int wx);
      return (wx + 1) / 2;
   endfunction

   // Requester index width, never narrower than one bit.
   function automatic int width_id(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Stage A: granted operand waiting for the square-root array.
   typedef struct packed {
      logic                  valid;
      logic [MaxWidthId-1:0] id;
      logic [MaxWidthX-1:0]  x;
   } stage_a_t;

   // Stage B: finished result presented on the response port.
   typedef struct packed {
      logic                  valid;
      logic [MaxWidthId-1:0] id;
      logic [MaxWidthQ-1:0]  q;
      logic [MaxWidthQ:0]    r;
   } stage_b_t;

endpackage

// File: rtl/sqrt_arbiter_sqrtarruns.sv
// Combinational unsigned integer square root (restoring digit-by-digit array).
// Produces q = floor(sqrt(x)) and r = x - q*q; r can need one bit more than q.
module SqrtArrUns
   import sqrt_arbiter_pkg::*;
#(
   parameter int widthX = 8,
   localparam int widthQ = width_q(widthX)
) (
   input  logic [widthX-1:0] x_i,
   output logic [widthQ-1:0] q_o,
   output logic [widthQ:0]   r_o
);

   logic [2*widthQ-1:0] xp;
   logic [widthQ+1:0]   rem;
   logic [widthQ+1:0]   trial;
   logic [widthQ-1:0]   root;

   // One root bit per operand bit pair, most significant pair first.
   always_comb begin
      // NOTE: blocking assignments here because each loop step reads the value the previous step just produced.
      xp    = (2*widthQ)'(x_i);
      rem   = '0;
      trial = '0;
      root  = '0;
      for (int i = widthQ - 1; i >= 0; i--) begin
         // The running remainder stays below 2^widthQ, so its top two bits are free for the shift.
         rem   = {rem[widthQ-1:0], xp[2*i +: 2]};
         trial = {root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = (root << 1) | widthQ'(1);
         end else begin
            root = root << 1;
         end
      end
      q_o = root;
      r_o = rem[widthQ:0];
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter in front of a two-stage square-root pipeline.
// Stage A holds the granted operand, stage B holds the finished result.
module sqrt_arbiter
   import sqrt_arbiter_pkg::*;
#(
   parameter int widthX = 8,
   parameter int NumReq = 4,
   localparam int widthQ  = width_q(widthX),
   localparam int widthId = width_id(NumReq)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumReq-1:0]        req_valid_i,
   output logic [NumReq-1:0]        req_ready_o,
   input  logic [NumReq*widthX-1:0] req_x_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [widthId-1:0]       rsp_id_o,
   output logic [widthQ-1:0]        rsp_q_o,
   output logic [widthQ:0]          rsp_r_o,
   output logic                     busy_o
);

   stage_a_t           stage_a;
   stage_b_t           stage_b;
   logic [widthId-1:0] last_grant;
   logic [widthId-1:0] grant_id;
   logic               grant_any;
   logic               b_free;
   logic               a_accept;
   logic [widthQ-1:0]  sq_q;
   logic [widthQ:0]    sq_r;

   // Pipeline advance: B empties on a pop, A moves whenever B makes room.
   assign b_free   = !stage_b.valid || rsp_ready_i;
   assign a_accept = !stage_a.valid || b_free;

   // Round-robin search starting just after the last winner.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      grant_id  = '0;
      grant_any = 1'b0;
      for (int i = 1; i <= NumReq; i++) begin
         if (!grant_any && req_valid_i[(int'(last_grant) + i) % NumReq]) begin
            grant_any = 1'b1;
            grant_id  = widthId'((int'(last_grant) + i) % NumReq);
         end
      end
      // No grant while stage A is blocked or while reset is held.
      if (!a_accept || rst_i) begin
         grant_any = 1'b0;
      end
      req_ready_o = grant_any ? (NumReq'(1) << grant_id) : '0;
   end

   SqrtArrUns #(
      .widthX(widthX)
   ) u_sqrt (
      .x_i(stage_a.x[widthX-1:0]),
      .q_o(sq_q),
      .r_o(sq_r)
   );

   // Stage registers and round-robin pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: the datapath fields are reset too, so the response port reads all-zero while reset is held.
      if (rst_i) begin
         stage_a    <= '0;
         stage_b    <= '0;
         last_grant <= widthId'(NumReq - 1);
      end else begin
         if (a_accept) begin
            stage_a.valid <= grant_any;
            if (grant_any) begin
               stage_a.id <= MaxWidthId'(grant_id);
               stage_a.x  <= MaxWidthX'(req_x_i[int'(grant_id)*widthX +: widthX]);
               last_grant <= grant_id;
            end
         end
         if (b_free) begin
            stage_b.valid <= stage_a.valid;
            stage_b.id    <= stage_a.id;
            stage_b.q     <= MaxWidthQ'(sq_q);
            stage_b.r     <= (MaxWidthQ + 1)'(sq_r);
         end
      end
   end

   assign rsp_valid_o = stage_b.valid;
   assign rsp_id_o    = stage_b.id[widthId-1:0];
   assign rsp_q_o     = stage_b.q[widthQ-1:0];
   assign rsp_r_o     = stage_b.r[widthQ:0];
   assign busy_o      = stage_a.valid || stage_b.valid;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed scenarios then random traffic,
// all compared against an in-order scoreboard and a round-robin reference.
module tb_sqrt_arbiter;

   localparam int WX = 8;
   localparam int NR = 4;
   localparam int WQ = (WX + 1) / 2;
   localparam int WI = 2;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*WX-1:0] req_x;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WI-1:0]    rsp_id;
   logic [WQ-1:0]    rsp_q;
   logic [WQ:0]      rsp_r;
   logic             busy;

   sqrt_arbiter #(
      .widthX(WX),
      .NumReq(NR)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_x_i    (req_x),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_id_o   (rsp_id),
      .rsp_q_o    (rsp_q),
      .rsp_r_o    (rsp_r),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int x;
      int age;
   } ent_t;

   ent_t          sb[$];
   int            last_g;
   int            waits[NR];
   int            granted;
   logic [NR-1:0] sampled_ready;
   int            n_checks;
   int            n_fail;
   int            n_ops;

   function automatic int ref_q(input int x);
      int q;
      q = 0;
      while ((q + 1) * (q + 1) <= x) q++;
      return q;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_x(input int n, input int v);
      req_x[n*WX +: WX] = WX'(v);
   endtask

   function automatic int get_x(input int n);
      return int'(req_x[n*WX +: WX]);
   endfunction

   // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
   task automatic tick();
      logic [NR-1:0] er;
      int            g;
      int            idx;
      logic          exp_v;
      logic          pop;
      #1;
      er = '0;
      g  = -1;
      if (!rst && !(sb.size() == 2 && !rsp_ready)) begin
         for (int i = 1; i <= NR; i++) begin
            idx = (last_g + i) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      sampled_ready = req_ready;
      check("req_ready", 32'(req_ready), 32'(er));
      exp_v = !rst && sb.size() > 0 && sb[0].age >= 1;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
         check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
         check("rsp_q", 32'(rsp_q), 32'(ref_q(sb[0].x)));
         check("rsp_r", 32'(rsp_r), 32'(sb[0].x - ref_q(sb[0].x) * ref_q(sb[0].x)));
      end
      check("busy", 32'(busy), 32'(!rst && sb.size() > 0));
      pop = exp_v && rsp_ready;
      for (int n = 0; n < NR; n++) begin
         if (!req_valid[n]) begin
            waits[n] = 0;
         end else if (n == g) begin
            check("fair_wait_ok", 32'(waits[n] <= NR - 1), 32'd1);
            waits[n] = 0;
         end else if (g >= 0) begin
            waits[n]++;
         end
      end
      @(posedge clk);
      if (rst) begin
         sb.delete();
         last_g = NR - 1;
         g      = -1;
         for (int n = 0; n < NR; n++) waits[n] = 0;
      end else begin
         if (pop) void'(sb.pop_front());
         foreach (sb[i]) sb[i].age++;
         if (g >= 0) begin
            sb.push_back('{id: g, x: get_x(g), age: 0});
            last_g = g;
            n_ops++;
         end
      end
      granted = g;
      #1;
   endtask

   initial begin
      int cyc;
      n_checks  = 0;
      n_fail    = 0;
      n_ops     = 0;
      last_g    = NR - 1;
      granted   = -1;
      rst       = 1'b1;
      req_valid = '0;
      req_x     = '0;
      rsp_ready = 1'b0;
      for (int n = 0; n < NR; n++) waits[n] = 0;
      @(posedge clk);
      #1;

      // Reset state
      tick();
      tick();
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_rsp_q", 32'(rsp_q), 32'd0);
      check("reset_rsp_r", 32'(rsp_r), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Requester 2 issues X=200
      rst       = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      set_x(2, 200);
      tick();
      req_valid = '0;
      tick();
      check("x200_valid", 32'(rsp_valid), 32'd1);
      check("x200_id", 32'(rsp_id), 32'd2);
      check("x200_q", 32'(rsp_q), 32'd14);
      check("x200_r", 32'(rsp_r), 32'd4);
      tick();

      // Boundaries from a single requester granted back to back
      req_valid = 4'b0001;
      set_x(0, 255);
      tick();
      set_x(0, 0);
      tick();
      check("x255_q", 32'(rsp_q), 32'd15);
      check("x255_r", 32'(rsp_r), 32'd30);
      set_x(0, 16);
      tick();
      check("x0_q", 32'(rsp_q), 32'd0);
      check("x0_r", 32'(rsp_r), 32'd0);
      check("x0_valid", 32'(rsp_valid), 32'd1);
      req_valid = '0;
      tick();
      check("x16_q", 32'(rsp_q), 32'd4);
      check("x16_r", 32'(rsp_r), 32'd0);
      tick();

      // Round-robin order with all requesters valid
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < NR; n++) set_x(n, 10 * n + 7);
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rr_order", 32'(sampled_ready), 32'(1 << (k % NR)));
      end
      req_valid = '0;
      for (int k = 0; k < 3; k++) tick();

      // Backpressure: two accepts then all grants withheld
      req_valid = '1;
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k < 2) check("stall_accept", 32'(sampled_ready), 32'(1 << k));
         else       check("stall_ready_low", 32'(sampled_ready), 32'd0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();

      // Reset while both stages hold entries
      req_valid = '1;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("full_before_reset", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_q", 32'(rsp_q), 32'd0);
      check("midrst_rsp_r", 32'(rsp_r), 32'd0);
      check("midrst_rsp_id", 32'(rsp_id), 32'd0);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      tick();
      check("first_grant_after_reset", 32'(sampled_ready), 32'd1);
      req_valid = '0;
      for (int k = 0; k < 3; k++) tick();

      // Random traffic against the scoreboard
      n_ops = 0;
      cyc   = 0;
      while (n_ops < 10000 && cyc < 60000) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
         for (int n = 0; n < NR; n++) begin
            if (n == granted) begin
               req_valid[n] = 1'($urandom_range(0, 1));
               set_x(n, int'($urandom_range(0, 255)));
            end else if (!req_valid[n]) begin
               req_valid[n] = ($urandom_range(0, 2) == 0);
               set_x(n, int'($urandom_range(0, 255)));
            end else if ($urandom_range(0, 3) == 0) begin
               set_x(n, int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 31) == 0) set_x(n, ($urandom_range(0, 1) != 0) ? 255 : 0);
         end
      end
      check("random_ops_done", 32'(n_ops >= 10000), 32'd1);
      req_valid = '0;
      rsp_ready = 1'b1;
      cyc       = 0;
      while (sb.size() > 0 && cyc < 10) begin
         tick();
         cyc++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
